// File: rtl/led_pkg.sv
// Shared types and constants for the POV row scheduler.
// Optional statistics outputs on the top are enabled with the ROW_STATS_EN macro.
package led_pkg;

  localparam int IMG_HEIGHT = 1024;
  localparam int ROW_W      = $clog2(IMG_HEIGHT);
  localparam int NUM_COLS   = 16;
  localparam int PIX_W      = 16;
  localparam int COL_W      = $clog2(NUM_COLS);
  localparam int STAT_W     = 16;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    START,
    BUSY
  } sched_state_t;

  // RGB565 black: every channel off.
  localparam pix_t BLACK = 16'h0000;

  // Debug view of the scheduler internals.
  typedef struct packed {
    sched_state_t state;
    row_t         last_row;
    logic         pend;
    logic         pend_blank;
  } sched_dbg_t;

endpackage

// File: rtl/row_event_detect.sv
// Turns the turn-timer row index and lock level into single-cycle events.
// row_evt: a new row while locked, or the first locked cycle.
// blank_evt: the timer lost lock (falling edge of row_valid).
module row_event_detect
  import led_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  row_t row,
  input  logic row_valid,
  output logic row_evt,
  output logic blank_evt,
  output row_t last_row
);

  logic valid_q;
  row_t last_row_q;

  assign row_evt   = row_valid && ((row != last_row_q) || !valid_q);
  assign blank_evt = valid_q && !row_valid;
  assign last_row  = last_row_q;

  // Remember the previous lock level and the last row that raised an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      last_row_q <= '1;
    end else begin
      valid_q <= row_valid;
      if (row_evt) last_row_q <= row;
    end
  end

endmodule

// File: rtl/row_scheduler.sv
// Row scheduler: fetches one row of column words from frame memory, loads the
// LED driver column bus, starts the driver and waits for it to finish.
// Build option: define ROW_STATS_EN to add the rows_dropped / rows_shown counters.
//
// Driver handshake: led_cmd_start is a one-cycle request; led_cols is held
// stable from that cycle until led_cmd_done is seen (done is ignored in the
// first cycle after start so a level-style done from the previous row cannot
// complete the new one). Memory: mem_rdata is valid exactly one cycle after mem_rd.
module row_scheduler
  import led_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROW_W-1:0]          row,
  input  logic                      row_valid,
  output logic                      mem_rd,
  output logic [ROW_W+COL_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]          mem_rdata,
  output logic                      led_cmd_start,
  input  logic                      led_cmd_done,
  output logic [NUM_COLS*PIX_W-1:0] led_cols,
  output logic                      busy,
`ifdef ROW_STATS_EN
  output logic [STAT_W-1:0]         rows_dropped,
  output logic [STAT_W-1:0]         rows_shown,
`endif
  output sched_dbg_t                dbg
);

  logic row_evt, blank_evt;
  row_t last_row;

  row_event_detect u_evt (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .row_valid (row_valid),
    .row_evt   (row_evt),
    .blank_evt (blank_evt),
    .last_row  (last_row)
  );

  sched_state_t     state_q, state_d;
  row_t             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d, cap_idx;
  row_t             pend_row_q, pend_row_d;
  logic             pend_q, pend_d;
  logic             pend_blank_q, pend_blank_d;
  logic             first_q, first_d;
  pix_t             cols_q [NUM_COLS];
  pix_t             cols_d [NUM_COLS];

  // Word written during a FETCH cycle is the one read in the previous cycle.
  assign cap_idx = col_q - COL_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      pend_row_q   <= '0;
      pend_q       <= 1'b0;
      pend_blank_q <= 1'b0;
      first_q      <= 1'b0;
      cols_q       <= '{default: BLACK};
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pend_row_q   <= pend_row_d;
      pend_q       <= pend_d;
      pend_blank_q <= pend_blank_d;
      first_q      <= first_d;
      cols_q       <= cols_d;
    end
  end

  // Next-state logic: pending bookkeeping first, then the sequencer.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    pend_row_d   = pend_row_q;
    pend_d       = pend_q;
    pend_blank_d = pend_blank_q;
    first_d      = 1'b0;
    cols_d       = cols_q;

    // Losing lock cancels any queued row; a newer row replaces an older one.
    if (blank_evt) begin
      pend_blank_d = 1'b1;
      pend_d       = 1'b0;
    end
    if (row_evt && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pend_row_d = row;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_blank_d) begin
          cols_d       = '{default: BLACK};
          pend_blank_d = 1'b0;
          state_d      = START;
        end else if (row_evt) begin
          row_d   = row;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (col_q != '0) cols_d[cap_idx] = mem_rdata;
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(NUM_COLS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        cols_d[NUM_COLS-1] = mem_rdata;
        state_d            = START;
      end
      START: begin
        first_d = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (!first_q && led_cmd_done) begin
          if (pend_blank_d) begin
            cols_d       = '{default: BLACK};
            pend_blank_d = 1'b0;
            state_d      = START;
          end else if (pend_d) begin
            row_d   = pend_row_d;
            pend_d  = 1'b0;
            col_d   = '0;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd        = (state_q == FETCH);
  assign mem_addr      = mem_rd ? {row_q, col_q} : '0;
  assign led_cmd_start = (state_q == START);
  assign busy          = (state_q != IDLE);

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_pack
    assign led_cols[g*PIX_W +: PIX_W] = cols_q[g];
  end

  assign dbg.state      = state_q;
  assign dbg.last_row   = last_row;
  assign dbg.pend       = pend_q;
  assign dbg.pend_blank = pend_blank_q;

`ifdef ROW_STATS_EN
  logic              drop;
  logic [STAT_W-1:0] dropped_q, shown_q;

  assign drop = row_evt && (state_q != IDLE) && pend_q;

  // Saturating drop counter and wrapping start counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= '0;
      shown_q   <= '0;
    end else begin
      if (state_q == START) shown_q <= shown_q + STAT_W'(1);
      if (drop && (dropped_q != '1)) dropped_q <= dropped_q + STAT_W'(1);
    end
  end

  assign rows_dropped = dropped_q;
  assign rows_shown   = shown_q;
`endif

endmodule

// File: tb/tb_row_scheduler.sv
// Directed bench for row_scheduler with a one-cycle-latency frame memory model
// whose word at address {row,col} is the zero-extended address itself.
module tb_row_scheduler;
  import led_pkg::*;

  logic                      clk;
  logic                      reset;
  logic [ROW_W-1:0]          row;
  logic                      row_valid;
  logic                      mem_rd;
  logic [ROW_W+COL_W-1:0]    mem_addr;
  logic [PIX_W-1:0]          mem_rdata;
  logic                      led_cmd_start;
  logic                      led_cmd_done;
  logic [NUM_COLS*PIX_W-1:0] led_cols;
  logic                      busy;
`ifdef ROW_STATS_EN
  logic [15:0]               rows_dropped;
  logic [15:0]               rows_shown;
`endif
  sched_dbg_t                dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] rd_q[$];
  int          rdc_q[$];
  int          st_q[$];

  row_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .row           (row),
    .row_valid     (row_valid),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .led_cmd_start (led_cmd_start),
    .led_cmd_done  (led_cmd_done),
    .led_cols      (led_cols),
    .busy          (busy),
`ifdef ROW_STATS_EN
    .rows_dropped  (rows_dropped),
    .rows_shown    (rows_shown),
`endif
    .dbg           (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: data one cycle after the read strobe, junk otherwise.
  always @(posedge clk) mem_rdata <= (mem_rd === 1'b1) ? {2'b00, mem_addr} : 16'hDEAD;

  // Monitor: log reads and starts stamped with the edge that samples them.
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      rd_q.push_back(mem_addr);
      rdc_q.push_back(cyc + 1);
    end
    if (led_cmd_start === 1'b1) st_q.push_back(cyc + 1);
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_logs();
    rd_q.delete(); rdc_q.delete(); st_q.delete(); exp_q.delete();
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 120 && st_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic drive_done();
    @(posedge clk); #1 led_cmd_done = 1'b1;
    @(posedge clk); #1 led_cmd_done = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_vec++; if (led_cmd_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b expected 0", led_cmd_start); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (led_cols !== '0) begin n_err++; $display("FAIL reset_cols: got %h expected 0", led_cols); end
    n_vec++; if (dbg.state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected IDLE", dbg.state); end
    n_vec++; if (dbg.last_row !== 10'h3FF) begin n_err++; $display("FAIL reset_last_row: got %h expected 3ff", dbg.last_row); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single_row();
    int n;
    logic [15:0] w;
    clear_logs();
    @(posedge clk); #1 row = 10'd5; row_valid = 1'b1;
    @(posedge clk); #1 n = cyc;
    wait_starts(1);
    for (int c = 0; c < 16; c++) exp_q.push_back({10'd5, 4'(c)});
    n_vec++; if (rd_q.size() != 16) begin n_err++; $display("FAIL single_nreads: got %0d expected 16", rd_q.size()); end
    else for (int c = 0; c < 16; c++) begin
      n_vec++; if (rd_q[c] !== exp_q[c]) begin n_err++; $display("FAIL single_addr[%0d]: got %h expected %h", c, rd_q[c], exp_q[c]); end
    end
    n_vec++; if (rdc_q.size() == 0 || rdc_q[0] != n + 1) begin n_err++; $display("FAIL single_first_rd: got %0d expected %0d", rdc_q.size() ? rdc_q[0] : -1, n + 1); end
    n_vec++; if (st_q.size() != 1 || st_q[0] != n + 18) begin n_err++; $display("FAIL single_start_edge: got %0d expected %0d", st_q.size() ? st_q[0] : -1, n + 18); end
    for (int c = 0; c < 16; c++) begin
      w = led_cols[c*16 +: 16];
      n_vec++; if (w !== 16'h0050 + 16'(c)) begin n_err++; $display("FAIL single_col[%0d]: got %h expected %h", c, w, 16'h0050 + 16'(c)); end
    end
    // done in the first BUSY cycle must be ignored
    led_cmd_done = 1'b1;
    @(posedge clk); #1 led_cmd_done = 1'b0;
    n_vec++; if (dbg.state !== BUSY) begin n_err++; $display("FAIL single_first_busy_done: got %0d expected BUSY", dbg.state); end
    repeat (5) @(posedge clk); #1;
    n_vec++; if (st_q.size() != 1) begin n_err++; $display("FAIL single_one_start: got %0d expected 1", st_q.size()); end
    w = led_cols[15*16 +: 16];
    n_vec++; if (w !== 16'h005F) begin n_err++; $display("FAIL single_cols_stable: got %h expected 005f", w); end
    drive_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [15:0] w;
    clear_logs();
    @(posedge clk); #1 row = 10'd7;
    wait_starts(1);
    row = 10'd8;
    @(posedge clk); #1 row = 10'd9;
    repeat (200) @(posedge clk); #1;
    clear_logs();
    drive_done();
    d = cyc;
    wait_starts(1);
    for (int c = 0; c < 16; c++) exp_q.push_back({10'd9, 4'(c)});
    n_vec++; if (rd_q.size() != 16) begin n_err++; $display("FAIL b2b_nreads: got %0d expected 16", rd_q.size()); end
    else for (int c = 0; c < 16; c++) begin
      n_vec++; if (rd_q[c] !== exp_q[c]) begin n_err++; $display("FAIL b2b_addr[%0d]: got %h expected %h", c, rd_q[c], exp_q[c]); end
    end
    n_vec++; if (rdc_q.size() == 0 || rdc_q[0] != d + 1) begin n_err++; $display("FAIL b2b_fetch_after_done: got %0d expected %0d", rdc_q.size() ? rdc_q[0] : -1, d + 1); end
    for (int c = 0; c < 16; c += 5) begin
      w = led_cols[c*16 +: 16];
      n_vec++; if (w !== 16'h0090 + 16'(c)) begin n_err++; $display("FAIL b2b_col[%0d]: got %h expected %h", c, w, 16'h0090 + 16'(c)); end
    end
`ifdef ROW_STATS_EN
    n_vec++; if (rows_dropped !== 16'd1) begin n_err++; $display("FAIL b2b_dropped: got %0d expected 1", rows_dropped); end
    n_vec++; if (rows_shown !== 16'd3) begin n_err++; $display("FAIL b2b_shown: got %0d expected 3", rows_shown); end
`endif
  endtask

  task automatic test_coincident();
    logic [15:0] w;
    clear_logs();
    repeat (3) @(posedge clk); #1 row = 10'd3; led_cmd_done = 1'b1;
    @(posedge clk); #1 led_cmd_done = 1'b0;
    n_vec++; if (dbg.state !== FETCH) begin n_err++; $display("FAIL coinc_state: got %0d expected FETCH", dbg.state); end
    n_vec++; if (mem_rd !== 1'b1 || mem_addr !== {10'd3, 4'd0}) begin n_err++; $display("FAIL coinc_rd: got %b/%h expected 1/%h", mem_rd, mem_addr, {10'd3, 4'd0}); end
    wait_starts(1);
    n_vec++; if (rd_q.size() != 16) begin n_err++; $display("FAIL coinc_nreads: got %0d expected 16", rd_q.size()); end
    w = led_cols[15*16 +: 16];
    n_vec++; if (w !== 16'h003F) begin n_err++; $display("FAIL coinc_col15: got %h expected 003f", w); end
    drive_done();
    n_vec++; if (dbg.state !== IDLE) begin n_err++; $display("FAIL coinc_idle: got %0d expected IDLE", dbg.state); end
  endtask

  task automatic test_blank();
    int d;
    clear_logs();
    @(posedge clk); #1 row = 10'd4;
    wait_starts(1);
    repeat (2) @(posedge clk); #1 row_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (led_cols === '0) begin n_err++; $display("FAIL blank_pre_cols: got %h expected nonzero", led_cols); end
    clear_logs();
    drive_done();
    d = cyc;
    wait_starts(1);
    n_vec++; if (rd_q.size() != 0) begin n_err++; $display("FAIL blank_no_reads: got %0d expected 0", rd_q.size()); end
    n_vec++; if (st_q.size() != 1 || st_q[0] != d + 1) begin n_err++; $display("FAIL blank_start: got %0d expected %0d", st_q.size() ? st_q[0] : -1, d + 1); end
    n_vec++; if (led_cols !== '0) begin n_err++; $display("FAIL blank_cols: got %h expected 0", led_cols); end
    drive_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL blank_idle: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    clear_logs();
    @(posedge clk); #1 row = 10'd1023; row_valid = 1'b1;
    wait_starts(1);
    drive_done();
    row = 10'd0;
    wait_starts(2);
    for (int c = 0; c < 16; c++) exp_q.push_back({10'd1023, 4'(c)});
    for (int c = 0; c < 16; c++) exp_q.push_back({10'd0, 4'(c)});
    n_vec++; if (rd_q.size() != 32) begin n_err++; $display("FAIL wrap_nreads: got %0d expected 32", rd_q.size()); end
    else for (int i = 0; i < 32; i++) begin
      n_vec++; if (rd_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, rd_q[i], exp_q[i]); end
    end
    n_vec++; if (st_q.size() != 2) begin n_err++; $display("FAIL wrap_starts: got %0d expected 2", st_q.size()); end
    for (int c = 0; c < 16; c += 3) begin
      w = led_cols[c*16 +: 16];
      n_vec++; if (w !== 16'(c)) begin n_err++; $display("FAIL wrap_col[%0d]: got %h expected %h", c, w, 16'(c)); end
    end
    drive_done();
    n_vec++; if (dbg.state !== IDLE) begin n_err++; $display("FAIL wrap_idle: got %0d expected IDLE", dbg.state); end
  endtask

  task automatic test_reset_mid_fetch();
    int  n;
    logic found;
    clear_logs();
    found = 1'b0;
    @(posedge clk); #1 row = 10'd2;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr === {10'd2, 4'd6}) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_col6: got %b expected 1", found); end
    #1 reset = 1'b1;
    #1;
    n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_rd: got %b expected 0", mem_rd); end
    n_vec++; if (dbg.state !== IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d expected IDLE", dbg.state); end
    n_vec++; if (led_cols !== '0) begin n_err++; $display("FAIL rstmid_cols: got %h expected 0", led_cols); end
    @(posedge clk); #1 reset = 1'b0;
    clear_logs();
    @(posedge clk); #1 n = cyc;
    wait_starts(1);
    for (int c = 0; c < 16; c++) exp_q.push_back({10'd2, 4'(c)});
    n_vec++; if (rd_q.size() != 16) begin n_err++; $display("FAIL rstmid_nreads: got %0d expected 16", rd_q.size()); end
    else for (int c = 0; c < 16; c++) begin
      n_vec++; if (rd_q[c] !== exp_q[c]) begin n_err++; $display("FAIL rstmid_addr[%0d]: got %h expected %h", c, rd_q[c], exp_q[c]); end
    end
    n_vec++; if (st_q.size() != 1 || st_q[0] != n + 18) begin n_err++; $display("FAIL rstmid_start_edge: got %0d expected %0d", st_q.size() ? st_q[0] : -1, n + 18); end
`ifdef ROW_STATS_EN
    n_vec++; if (rows_shown !== 16'd1 || rows_dropped !== 16'd0) begin n_err++; $display("FAIL rstmid_stats: got %0d/%0d expected 1/0", rows_shown, rows_dropped); end
`endif
    drive_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
  endtask

  initial begin
    reset        = 1'b1;
    row          = '0;
    row_valid    = 1'b0;
    led_cmd_done = 1'b0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_coincident();
    test_blank();
    test_wrap();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
